// File: rtl/sipo_deser.sv
// sipo_deser: serial-in / parallel-out deserializer.
// Collects n symbols of width bits into one word and offers it on a
// valid/ready port. sof realigns the frame. A completed word that finds
// the output still occupied is dropped and flags a sticky overrun.
// Optional build macro: DESER_MSBFIRST_EN (first symbol lands in the top
// slot of dout instead of the bottom slot).
module sipo_deser #(
    parameter int n     = 4,
    parameter int width = 1,
    localparam int CW   = (n > 1) ? $clog2(n) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [width-1:0]   si,
    input  logic               sof,
    output logic [n*width-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               overrun,
    input  logic               clr_ovr,
    output logic [CW-1:0]      cnt
);

    localparam int W = n * width;

    logic [W-1:0] shreg;
    logic [W-1:0] base;
    logic [W-1:0] word;
    logic         last;
    logic         done;
    logic         load;
    logic         drop;

    // Next assembly value, completion detect and delivery decision.
    // sof clears the shift base so a discarded partial frame leaves no trace.
    always_comb begin
        base = sof ? '0 : shreg;
`ifdef DESER_MSBFIRST_EN
        word = {base[W-width-1:0], si};
`else
        word = {si, base[W-1:width]};
`endif
        last = !sof && (cnt == CW'(n - 1));
        done = en && last;
        load = done && (!dout_valid || dout_ready);
        drop = done && dout_valid && !dout_ready;
    end

    // Assembly register and symbol counter; advance only on accepted symbols.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (en) begin
            shreg <= word;
            if (sof)
                cnt <= CW'(1);
            else if (last)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    // Output word register with valid/ready handshake; dout only changes
    // when a new word is actually loaded, so it is stable under backpressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (load) begin
            dout       <= word;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    // Sticky overrun; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            overrun <= 1'b0;
        else if (drop)
            overrun <= 1'b1;
        else if (clr_ovr)
            overrun <= 1'b0;
    end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-in/parallel-out deserializer that sits directly downstream of the parallel-load shift register and consumes its serial output stream. It collects n symbols of width bits each into one word, then presents the word on a valid/ready output port. Frame alignment comes from a start-of-frame strobe. Any completed word that cannot be delivered is dropped and flagged.

Parameters:
n, 4, symbols per word (n >= 2)
width, 1, bits per symbol
CW, $clog2(n) (localparam), symbol counter width

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
en  input  1  symbol strobe; si is sampled on a rising edge of clk when en=1
si  input  width  serial symbol (the shift register's so)
sof  input  1  start of frame; qualified by en
dout  output  n*width  assembled word
dout_valid  output  1  dout holds an undelivered word
dout_ready  input  1  consumer accepts dout this cycle
overrun  output  1  sticky: a completed word was dropped
clr_ovr  input  1  synchronous clear of overrun
cnt  output  CW  symbols collected in the current frame (debug)

Behaviour:
- Reset (rstn=0, asynchronous): assembly register=0, cnt=0, dout=0, dout_valid=0, overrun=0. Reset takes effect immediately, including mid-frame, and any partial frame is lost.
- Accept: a symbol is accepted on a clk edge with en=1. Cycles with en=0 hold all state.
- Bit order (default, LSB-first): the first symbol of a frame lands in dout[width-1:0] and symbol k lands in dout[k*width +: width]. This matches the upstream right-shift order.
- Assembly: on accept, shift right by width and insert si at the top: asm <= {si, asm[n*width-1:width]}. Increment cnt.
- sof with en: the symbol is taken as symbol 0. Any partial frame is discarded and cnt becomes 1.
- sof without en: ignored.
- Word completion: the accept with cnt==n-1 (or sof with n==1, which is excluded by n>=2) completes the word.
  - cnt wraps to 0.
  - The completed word is {si, asm[n*width-1:width]}.
- Transfer on completion:
  - If dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle, then on the next edge dout = completed word and dout_valid=1.
  - Latency is 1 cycle from the nth symbol edge to dout_valid high.
  - Otherwise (dout_valid=1, dout_ready=0) the completed word is dropped: dout is unchanged, overrun<=1, and cnt still wraps to 0.
- Handshake:
  - A word is transferred when dout_valid && dout_ready on an edge; dout_valid then falls on that edge unless a new word completes in the same cycle.
  - dout is stable while dout_valid=1 and dout_ready=0.
  - dout_ready while dout_valid=0 has no effect.
- overrun: sticky until clr_ovr=1. If clr_ovr=1 and a new drop happen on the same edge, the set wins (overrun stays 1).
- No combinational path exists from inputs to outputs; all outputs are registered.

Optional Feature:
DESER_MSBFIRST_EN
- Defined: the first symbol of a frame lands in dout[n*width-1 -: width]. The assembly register shifts left: asm <= {asm[n*width-width-1:0], si}. All timing, handshake and overrun rules are unchanged.
- Undefined: LSB-first as specified above.

Test Plan:
- Reset then n=4, width=1, en=1 continuous, sof on the first symbol, si = 1,0,1,1, dout_ready=1 -> dout_valid high 1 cycle after the 4th symbol, dout=4'b1101, overrun=0.
- en gaps: the same 4 symbols spread with en=0 cycles between them -> identical dout=4'b1101; cnt holds its value during gaps.
- Backpressure: dout_ready=0, two full frames (1,0,1,1 then 0,0,0,1) -> dout stays 4'b1101, overrun=1 after the 2nd frame. Then clr_ovr=1 -> overrun=0.
- Resync: sof, symbols 1,1 (partial), then sof with 0,1,0,0 -> single word dout=4'b0010; no word is emitted for the partial frame.
- Back-to-back with dout_ready=1 and a completion on the same edge the previous word drains -> dout updates to the new word, dout_valid stays 1, overrun=0.
- Async reset asserted mid-frame (after 2 symbols) and mid-hold (dout_valid=1) -> all outputs 0 immediately. Next frame 0,1,1,0 after release -> dout=4'b0110. With DESER_MSBFIRST_EN, the same frame gives dout=4'b0110 reversed, i.e. 4'b0110.
